pixel_array_ctrl: RTL and testbench

- Sequencing controller directly upstream of the pixel array. It drives ERASE, EXPOSE, RESET, ramp enable, the 8-bit ADC counter onto the shared DATA bus, and the per-pixel READ selects.
- It captures each pixel's digitised value from DATA and streams it to the readout stage with a valid/ready handshake. One frame is captured per START request.

---
 rtl/pixel_array_ctrl.sv | 159 +++++++++++++++
 tb/tb_pixel_array_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/pixel_array_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pixel_array_ctrl
//  Description : Sequences erase/expose/ramp-convert on a pixel array, then
//                reads each pixel off the shared DATA bus into a valid/ready
//                stream.
//  Revision    : 1.0  initial release
// ============================================================================
module pixel_array_ctrl #(
   parameter int ROW_NUM       = 2,
   parameter int COLUMN_NUM    = 2,
   parameter int ERASE_CYCLES  = 5,
   parameter int EXPOSE_CYCLES = 255
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  START,
   output logic                  ERASE,
   output logic                  EXPOSE,
   output logic                  RESET,
   output logic                  RAMP_EN,
   output logic [ROW_NUM*COLUMN_NUM-1:0] READ,
   inout  wire  [7:0]            DATA,
   output logic [7:0]            PIXEL_DATA,
   output logic [((ROW_NUM*COLUMN_NUM) > 1 ? $clog2(ROW_NUM*COLUMN_NUM) : 1)-1:0] PIXEL_INDEX,
   output logic                  PIXEL_VALID,
   input  logic                  PIXEL_READY,
   output logic                  BUSY,
   output logic                  FRAME_DONE
);

   localparam int c_n_pix   = ROW_NUM * COLUMN_NUM;
   localparam int c_idx_w   = (c_n_pix > 1) ? $clog2(c_n_pix) : 1;
   localparam int c_max_ee  = (ERASE_CYCLES > EXPOSE_CYCLES) ? ERASE_CYCLES : EXPOSE_CYCLES;
   localparam int c_cnt_max = (c_max_ee > 256) ? c_max_ee : 256;
   localparam int c_cnt_w   = $clog2(c_cnt_max + 1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ERASE   = 3'd1,
      S_EXPOSE  = 3'd2,
      S_CONVERT = 3'd3,
      S_TURN    = 3'd4,
      S_RD_SEL  = 3'd5,
      S_RD_OUT  = 3'd6,
      S_DONE    = 3'd7
   } state_t;

   state_t               r_state;
   state_t               w_next;
   logic [c_cnt_w-1:0]   r_cnt;
   logic [c_idx_w-1:0]   r_pix;
   logic                 r_valid;
   logic [7:0]           r_pdata;
   logic [c_idx_w-1:0]   r_pidx;
   logic                 w_timed;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next     = r_state;
      ERASE      = 1'b0;
      RESET      = 1'b0;
      EXPOSE     = 1'b0;
      RAMP_EN    = 1'b0;
      FRAME_DONE = 1'b0;
      BUSY       = (r_state != S_IDLE);
      w_timed    = 1'b0;
      READ       = '0;
      case (r_state)
         S_IDLE: begin
            if (START) w_next = S_ERASE;
         end
         S_ERASE: begin
            ERASE   = 1'b1;
            RESET   = 1'b1;
            w_timed = 1'b1;
            if (r_cnt == c_cnt_w'(ERASE_CYCLES - 1)) w_next = S_EXPOSE;
         end
         S_EXPOSE: begin
            EXPOSE  = 1'b1;
            w_timed = 1'b1;
            if (r_cnt == c_cnt_w'(EXPOSE_CYCLES - 1)) w_next = S_CONVERT;
         end
         S_CONVERT: begin
            RAMP_EN = 1'b1;
            w_timed = 1'b1;
            if (r_cnt == c_cnt_w'(255)) w_next = S_TURN;
         end
         S_TURN: begin
            w_next = S_RD_SEL;
         end
         S_RD_SEL: begin
            for (int k = 0; k < c_n_pix; k++) begin
               READ[k] = (r_pix == c_idx_w'(k));
            end
            w_next = S_RD_OUT;
         end
         S_RD_OUT: begin
            if (PIXEL_READY) begin
               w_next = (r_pix == c_idx_w'(c_n_pix - 1)) ? S_DONE : S_RD_SEL;
            end
         end
         S_DONE: begin
            FRAME_DONE = 1'b1;
            w_next     = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Counter restarts from zero on every state change, so the ramp never wraps visibly.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt   <= '0;
         r_pix   <= '0;
         r_valid <= 1'b0;
         r_pdata <= '0;
         r_pidx  <= '0;
      end else begin
         if (w_next != r_state) begin
            r_cnt <= '0;
         end else if (w_timed) begin
            r_cnt <= r_cnt + c_cnt_w'(1);
         end
         case (r_state)
            S_IDLE: begin
               r_pix <= '0;
            end
            S_RD_SEL: begin
               r_pdata <= DATA;
               r_pidx  <= r_pix;
               r_valid <= 1'b1;
            end
            S_RD_OUT: begin
               if (PIXEL_READY) begin
                  r_valid <= 1'b0;
                  r_pix   <= (r_pix == c_idx_w'(c_n_pix - 1)) ? '0 : r_pix + c_idx_w'(1);
               end
            end
            default: ;
         endcase
      end
   end

   // Bus is released outside CONVERT; TURN gives a dead cycle before pixels drive it.
   assign DATA        = (r_state == S_CONVERT) ? r_cnt[7:0] : 8'bz;
   assign PIXEL_DATA  = r_pdata;
   assign PIXEL_INDEX = r_pidx;
   assign PIXEL_VALID = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_pixel_array_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pixel_array_ctrl
//  Description : Self-checking bench: frame timing by cycle arithmetic, pixel
//                stream checked against an expected-pixel queue.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pixel_array_ctrl;

   localparam int c_e     = 5;
   localparam int c_x     = 255;
   localparam int c_n     = 4;
   localparam int c_ramp0 = 1 + c_e + c_x;   // first CONVERT cycle after START edge
   localparam int c_turn  = c_ramp0 + 256;   // bus turnaround cycle

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       START = 1'b0;
   logic       PIXEL_READY = 1'b0;
   logic       ERASE, EXPOSE, RESET, RAMP_EN, PIXEL_VALID, BUSY, FRAME_DONE;
   logic [3:0] READ;
   logic [7:0] PIXEL_DATA;
   logic [1:0] PIXEL_INDEX;
   wire  [7:0] DATA;

   logic [7:0] lat [c_n];
   logic [7:0] tgt [c_n];
   logic [7:0] pix_val;

   int n_chk = 0;
   int n_err = 0;

   typedef struct {
      logic [7:0] t0, t1, t2, t3;
      int         stall_pix;
      int         stall_len;
      bit         poke;
      int         exp_done;
   } vec_t;

   typedef struct {
      int idx;
      int val;
   } pix_t;

   pix_t q[$];
   vec_t vecs[4];

   pixel_array_ctrl #(
      .ROW_NUM(2), .COLUMN_NUM(2), .ERASE_CYCLES(c_e), .EXPOSE_CYCLES(c_x)
   ) dut (
      .clk(clk), .reset_n(reset_n), .START(START),
      .ERASE(ERASE), .EXPOSE(EXPOSE), .RESET(RESET), .RAMP_EN(RAMP_EN),
      .READ(READ), .DATA(DATA),
      .PIXEL_DATA(PIXEL_DATA), .PIXEL_INDEX(PIXEL_INDEX),
      .PIXEL_VALID(PIXEL_VALID), .PIXEL_READY(PIXEL_READY),
      .BUSY(BUSY), .FRAME_DONE(FRAME_DONE)
   );

   always #5 clk = ~clk;

   // Pixel model: the selected pixel drives its latched ramp value onto the bus.
   always_comb begin
      pix_val = '0;
      for (int k = 0; k < c_n; k++) if (READ[k]) pix_val = lat[k];
   end
   assign DATA = (READ != 4'b0) ? pix_val : 8'bz;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run_frame(input int stall_pix, input int stall_len, input bit poke,
                            input bit rnd_ready, input int abort_at, input int exp_done);
      int         c;
      int         vcnt;
      int         ndone;
      bit         e, x, r;
      logic [7:0] exp_vec;
      q.delete();
      for (int k = 0; k < c_n; k++) begin
         q.push_back('{idx: k, val: int'(tgt[k])});
         lat[k] = ~tgt[k];
      end
      PIXEL_READY = 1'b1;
      START = 1'b1;
      step();
      START = 1'b0;
      c = 1;
      while (c <= c_turn) begin
         e = (c <= c_e);
         x = (c > c_e) && (c < c_ramp0);
         r = (c >= c_ramp0) && (c < c_turn);
         exp_vec = {e, e, x, r, 1'b1, 3'b000};
         chk($sformatf("phase c=%0d", c),
             int'({ERASE, RESET, EXPOSE, RAMP_EN, BUSY, FRAME_DONE, PIXEL_VALID, |READ}),
             int'(exp_vec));
         if (r) begin
            chk($sformatf("ramp c=%0d", c), int'(DATA), c - c_ramp0);
            for (int k = 0; k < c_n; k++) if (DATA == tgt[k]) lat[k] = DATA;
         end
         if (c == abort_at) begin
            reset_n = 1'b0;
            #1;
            chk("abort_outputs",
                int'({ERASE, RESET, EXPOSE, RAMP_EN, BUSY, FRAME_DONE, PIXEL_VALID,
                      READ, PIXEL_DATA, PIXEL_INDEX}), 0);
            step();
            reset_n = 1'b1;
            for (int i = 0; i < 4; i++) begin
               step();
               chk("abort_idle", int'({BUSY, FRAME_DONE, READ}), 0);
            end
            return;
         end
         START = poke && (c == c_ramp0 - 100 || c == c_ramp0 + 50);
         step();
         c++;
      end
      vcnt  = 0;
      ndone = 0;
      while (BUSY && c < c_turn + 2000) begin
         if (READ != 4'b0) begin
            chk("read_onehot", int'(READ), (q.size() > 0) ? (1 << q[0].idx) : 0);
            chk("read_vs_bus", int'({PIXEL_VALID, RAMP_EN}), 0);
         end
         if (PIXEL_VALID) begin
            chk("read_while_valid", int'(READ), 0);
            if (q.size() > 0) begin
               chk("pixel_index", int'(PIXEL_INDEX), q[0].idx);
               chk("pixel_data", int'(PIXEL_DATA), q[0].val);
            end else begin
               chk("extra_valid", 1, 0);
            end
         end
         if (FRAME_DONE) begin
            ndone++;
            chk("done_pending", q.size(), 0);
            if (exp_done >= 0) chk("done_cycle", c, exp_done);
         end
         if (rnd_ready) PIXEL_READY = ($urandom_range(0, 3) != 0);
         else PIXEL_READY = !(PIXEL_VALID && q.size() > 0 && q[0].idx == stall_pix
                              && vcnt < stall_len);
         if (PIXEL_VALID && !PIXEL_READY) vcnt++;
         if (PIXEL_VALID && PIXEL_READY && q.size() > 0) void'(q.pop_front());
         step();
         c++;
      end
      chk("busy_timeout", int'(BUSY), 0);
      chk("done_count", ndone, 1);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("idle_after", int'({BUSY, FRAME_DONE, READ, PIXEL_VALID}), 0);
         chk("hold_pixel", int'(PIXEL_DATA), int'(tgt[c_n - 1]));
      end
   endtask

   initial begin
      vecs[0] = '{t0: 8'd17,  t1: 8'd200, t2: 8'd0,   t3: 8'd255, stall_pix: -1, stall_len: 0,  poke: 1'b0, exp_done: 526};
      vecs[1] = '{t0: 8'd5,   t1: 8'd99,  t2: 8'd128, t3: 8'd254, stall_pix: 2,  stall_len: 10, poke: 1'b0, exp_done: 536};
      vecs[2] = '{t0: 8'd255, t1: 8'd1,   t2: 8'd77,  t3: 8'd33,  stall_pix: -1, stall_len: 0,  poke: 1'b1, exp_done: 526};
      vecs[3] = '{t0: 8'd0,   t1: 8'd0,   t2: 8'd255, t3: 8'd255, stall_pix: 0,  stall_len: 3,  poke: 1'b0, exp_done: 529};

      for (int k = 0; k < c_n; k++) lat[k] = '0;
      step();
      step();
      chk("reset_state",
          int'({ERASE, RESET, EXPOSE, RAMP_EN, BUSY, FRAME_DONE, PIXEL_VALID,
                READ, PIXEL_DATA, PIXEL_INDEX}), 0);
      reset_n = 1'b1;
      step();
      chk("idle_no_start", int'(BUSY), 0);

      for (int i = 0; i < 4; i++) begin
         tgt[0] = vecs[i].t0;
         tgt[1] = vecs[i].t1;
         tgt[2] = vecs[i].t2;
         tgt[3] = vecs[i].t3;
         run_frame(vecs[i].stall_pix, vecs[i].stall_len, vecs[i].poke, 1'b0, -1,
                   vecs[i].exp_done);
      end

      // Abort mid-CONVERT with counter at 100, then a normal frame.
      for (int k = 0; k < c_n; k++) tgt[k] = 8'($urandom_range(0, 255));
      run_frame(-1, 0, 1'b0, 1'b0, c_ramp0 + 100, -1);
      run_frame(-1, 0, 1'b0, 1'b0, -1, 526);

      for (int f = 0; f < 3; f++) begin
         for (int k = 0; k < c_n; k++) tgt[k] = 8'($urandom_range(0, 255));
         run_frame(-1, 0, 1'b0, 1'b1, -1, -1);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
